// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with operand forwarding, EX/MEM register and iterative mul/div unit holding HI/LO
module ex_stage_md #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         EXMEMop,
  input  logic [1:0]         busAMUX,
  input  logic [1:0]         busBMUX,
  input  logic [DATA_W-1:0]  busA,
  input  logic [DATA_W-1:0]  busB,
  input  logic [DATA_W-1:0]  Imm,
  input  logic [DATA_W-1:0]  PCplus4,
  input  logic [DATA_W-1:0]  WB_RegWriteData,
  input  logic [4:0]         Shamt,
  input  logic               ALUSrcA,
  input  logic               ALUSrcB,
  input  logic               ALUorRA,
  input  logic               Sign,
  input  logic [CTRL_W-1:0]  ALUCtrl,
  input  logic [2:0]         MDop,
  input  logic               RegWrite,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               MemtoReg,
  input  logic [RADDR_W-1:0] WriteRegAddr,
  input  logic [RADDR_W-1:0] rt,
  output logic               stall_req,
  output logic               md_busy,
  output logic [DATA_W-1:0]  EXMEM_ALUout,
  output logic [DATA_W-1:0]  EXMEM_MemWriteData,
  output logic               EXMEM_RegWrite,
  output logic               EXMEM_MemRead,
  output logic               EXMEM_MemWrite,
  output logic               EXMEM_MemtoReg,
  output logic [RADDR_W-1:0] EXMEM_WriteRegAddr,
  output logic [RADDR_W-1:0] EXMEM_rt,
  output logic [DATA_W-1:0]  HI,
  output logic [DATA_W-1:0]  LO
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W);

  localparam logic [CTRL_W-1:0] ALU_ADD  = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_SUB  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_AND  = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_OR   = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_XOR  = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_NOR  = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_SLT  = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_SLL  = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALU_SRL  = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_SRA  = CTRL_W'(9);
  localparam logic [CTRL_W-1:0] ALU_LUI  = CTRL_W'(10);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} md_state_e;

  md_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

  logic [DATA_W-1:0]   real_a, real_b, alu_a, alu_b, alu_out, ex_result;
  logic                alu_lt, md_start, start_div, start_signed, a_neg, b_neg;
  logic [DATA_W:0]     mul_sum, div_shift, div_diff;
  logic [2*DATA_W-1:0] prod;

  assign real_a = (busAMUX == 2'd1) ? EXMEM_ALUout : (busAMUX == 2'd2) ? WB_RegWriteData : busA;
  assign real_b = (busBMUX == 2'd1) ? EXMEM_ALUout : (busBMUX == 2'd2) ? WB_RegWriteData : busB;
  assign alu_a  = ALUSrcA ? {{(DATA_W-5){1'b0}}, Shamt} : real_a;
  assign alu_b  = ALUSrcB ? Imm : real_b;
  assign alu_lt = Sign ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);

  always_comb begin
    alu_out = '0;
    case (ALUCtrl)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_NOR: alu_out = ~(alu_a | alu_b);
      ALU_SLT: alu_out = {{(DATA_W-1){1'b0}}, alu_lt};
      ALU_SLL: alu_out = alu_b << alu_a[SH_W-1:0];
      ALU_SRL: alu_out = alu_b >> alu_a[SH_W-1:0];
      ALU_SRA: alu_out = $signed(alu_b) >>> alu_a[SH_W-1:0];
      ALU_LUI: alu_out = alu_b << (DATA_W / 2);
      default: alu_out = '0;
    endcase
  end

  assign ex_result = (MDop == 3'd5) ? hi_q : (MDop == 3'd6) ? lo_q : ALUorRA ? PCplus4 : alu_out;

  assign md_busy      = (state_q != S_IDLE);
  assign stall_req    = md_busy && (MDop >= 3'd1) && (MDop <= 3'd6);
  assign md_start     = (MDop >= 3'd1) && (MDop <= 3'd4) && (EXMEMop == 2'd0) && !md_busy;
  assign start_div    = (MDop == 3'd3) || (MDop == 3'd4);
  assign start_signed = (MDop == 3'd1) || (MDop == 3'd3);
  assign a_neg        = start_signed && real_a[DATA_W-1];
  assign b_neg        = start_signed && real_b[DATA_W-1];

  // Multiply: shift-add into {acc_hi, acc_lo}. Divide: restoring, remainder in acc_hi, quotient in acc_lo.
  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign prod      = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (md_start) begin
          state_d  = S_ITER;
          cnt_d    = '0;
          is_div_d = start_div;
          acc_hi_d = '0;
          acc_lo_d = start_div ? (a_neg ? -real_a : real_a) : (b_neg ? -real_b : real_b);
          opnd_d   = start_div ? (b_neg ? -real_b : real_b) : (a_neg ? -real_a : real_a);
          // A zero divisor keeps the quotient positive so LO ends all ones.
          neg_lo_d = (a_neg ^ b_neg) && !(start_div && (real_b == '0));
          neg_hi_d = a_neg;
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          if (!div_diff[DATA_W]) begin
            acc_hi_d = div_diff[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_hi_d = div_shift[DATA_W-1:0];
            acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          acc_hi_d = mul_sum[DATA_W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? -acc_lo_q : acc_lo_q;
          hi_d = neg_hi_q ? -acc_hi_q : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_lo_q ? -prod : prod;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  always_ff @(posedge clk) begin
    if (reset || (!EXMEMop[1] && (EXMEMop[0] || stall_req))) begin
      EXMEM_ALUout       <= '0;
      EXMEM_MemWriteData <= '0;
      EXMEM_RegWrite     <= 1'b0;
      EXMEM_MemRead      <= 1'b0;
      EXMEM_MemWrite     <= 1'b0;
      EXMEM_MemtoReg     <= 1'b0;
      EXMEM_WriteRegAddr <= '0;
      EXMEM_rt           <= '0;
    end else if (!EXMEMop[1]) begin
      EXMEM_ALUout       <= ex_result;
      EXMEM_MemWriteData <= real_b;
      EXMEM_RegWrite     <= RegWrite;
      EXMEM_MemRead      <= MemRead;
      EXMEM_MemWrite     <= MemWrite;
      EXMEM_MemtoReg     <= MemtoReg;
      EXMEM_WriteRegAddr <= WriteRegAddr;
      EXMEM_rt           <= rt;
    end
  end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - randomized self-checking bench for ex_stage_md against a behavioural model
module tb_ex_stage_md;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] EXMEMop, busAMUX, busBMUX;
  logic [W-1:0] busA, busB, Imm, PCplus4, WB_RegWriteData;
  logic [4:0] Shamt, ALUCtrl, WriteRegAddr, rt;
  logic ALUSrcA, ALUSrcB, ALUorRA, Sign, RegWrite, MemRead, MemWrite, MemtoReg;
  logic [2:0] MDop;
  logic stall_req, md_busy;
  logic [W-1:0] EXMEM_ALUout, EXMEM_MemWriteData, HI, LO;
  logic EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg;
  logic [4:0] EXMEM_WriteRegAddr, EXMEM_rt;

  always #5 clk = ~clk;

  ex_stage_md #(.DATA_W(W), .RADDR_W(5), .CTRL_W(5)) dut (
    .clk(clk), .reset(reset), .EXMEMop(EXMEMop), .busAMUX(busAMUX), .busBMUX(busBMUX),
    .busA(busA), .busB(busB), .Imm(Imm), .PCplus4(PCplus4), .WB_RegWriteData(WB_RegWriteData),
    .Shamt(Shamt), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUorRA(ALUorRA), .Sign(Sign),
    .ALUCtrl(ALUCtrl), .MDop(MDop), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .WriteRegAddr(WriteRegAddr), .rt(rt), .stall_req(stall_req),
    .md_busy(md_busy), .EXMEM_ALUout(EXMEM_ALUout), .EXMEM_MemWriteData(EXMEM_MemWriteData),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_MemtoReg(EXMEM_MemtoReg), .EXMEM_WriteRegAddr(EXMEM_WriteRegAddr), .EXMEM_rt(EXMEM_rt),
    .HI(HI), .LO(LO)
  );

  int checks = 0;
  int failures = 0;
  logic [77:0] exp_exmem;
  logic [W-1:0] m_hi, m_lo;
  logic [77:0] dut_exmem;
  assign dut_exmem = {EXMEM_ALUout, EXMEM_MemWriteData, EXMEM_RegWrite, EXMEM_MemRead,
                      EXMEM_MemWrite, EXMEM_MemtoReg, EXMEM_WriteRegAddr, EXMEM_rt};

  function automatic logic [31:0] m_alu(input logic [4:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic sgn);
    case (c)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return ~(a | b);
      5'd6:  return sgn ? 32'($signed(a) < $signed(b)) : 32'(a < b);
      5'd7:  return b << a[4:0];
      5'd8:  return b >> a[4:0];
      5'd9:  return $signed(b) >>> a[4:0];
      5'd10: return {b[15:0], 16'd0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] m_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qa = $signed(a);
    qb = $signed(b);
    case (op)
      3'd1: return 64'(sa * sb);
      3'd2: return {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(qa % qb), 32'(qa / qb)};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Advance the expected EX/MEM entry for the inputs currently driven.
  task automatic model_edge(input bit stall_exp);
    logic [31:0] ra, rb, a1, b1, res, fwd;
    fwd = exp_exmem[77:46];
    ra = (busAMUX == 2'd1) ? fwd : (busAMUX == 2'd2) ? WB_RegWriteData : busA;
    rb = (busBMUX == 2'd1) ? fwd : (busBMUX == 2'd2) ? WB_RegWriteData : busB;
    a1 = ALUSrcA ? {27'd0, Shamt} : ra;
    b1 = ALUSrcB ? Imm : rb;
    if (MDop == 3'd5)      res = m_hi;
    else if (MDop == 3'd6) res = m_lo;
    else if (ALUorRA)      res = PCplus4;
    else                   res = m_alu(ALUCtrl, a1, b1, Sign);
    if (!EXMEMop[1]) begin
      if (EXMEMop == 2'd1 || stall_exp) exp_exmem = '0;
      else exp_exmem = {res, rb, RegWrite, MemRead, MemWrite, MemtoReg, WriteRegAddr, rt};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    EXMEMop = 0; busAMUX = 0; busBMUX = 0; busA = 0; busB = 0; Imm = 0; PCplus4 = 0;
    WB_RegWriteData = 0; Shamt = 0; ALUSrcA = 0; ALUSrcB = 0; ALUorRA = 0; Sign = 0;
    ALUCtrl = 0; MDop = 0; RegWrite = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0;
    WriteRegAddr = 0; rt = 0;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [63:0] r;
    int n;
    set_idle();
    MDop = op; busA = a; busB = b;
    model_edge(0);
    r = m_md(op, a, b);
    tick();
    set_idle();
    n = 0;
    while (md_busy === 1'b1 && n < 100) begin
      n++;
      model_edge(0);
      tick();
    end
    m_hi = r[63:32];
    m_lo = r[31:0];
    checks++;
    if (n != W + 1) begin failures++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, n, W + 1); end
    checks++;
    if (HI !== m_hi) begin failures++; $display("FAIL %s HI: got %h expected %h", name, HI, m_hi); end
    checks++;
    if (LO !== m_lo) begin failures++; $display("FAIL %s LO: got %h expected %h", name, LO, m_lo); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    tick();
    tick();
    reset = 1'b0;
    exp_exmem = '0; m_hi = '0; m_lo = '0;
    checks++;
    if (dut_exmem !== 78'd0) begin failures++; $display("FAIL reset exmem: got %h expected 0", dut_exmem); end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL reset hilo: got %h/%h expected 0/0", HI, LO); end
    checks++;
    if (md_busy !== 1'b0) begin failures++; $display("FAIL reset md_busy: got %b expected 0", md_busy); end
    checks++;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL reset stall_req: got %b expected 0", stall_req); end
  endtask

  task automatic test_forwarding();
    set_idle();
    busA = 2; busB = 3; RegWrite = 1; WriteRegAddr = 3;
    model_edge(0); tick();
    checks++;
    if (EXMEM_ALUout !== 32'd5) begin failures++; $display("FAIL fwd base: got %0d expected 5", EXMEM_ALUout); end
    busA = 1; busAMUX = 1; busB = 7;
    model_edge(0); tick();
    checks++;
    if (EXMEM_ALUout !== 32'd12) begin failures++; $display("FAIL fwd exmem: got %0d expected 12", EXMEM_ALUout); end
    busAMUX = 2; WB_RegWriteData = 100;
    model_edge(0); tick();
    checks++;
    if (EXMEM_ALUout !== 32'd107) begin failures++; $display("FAIL fwd wb: got %0d expected 107", EXMEM_ALUout); end
    busAMUX = 0; busBMUX = 1; busA = 4;
    model_edge(0); tick();
    checks++;
    if (dut_exmem !== exp_exmem) begin failures++; $display("FAIL fwd busB: got %h expected %h", dut_exmem, exp_exmem); end
  endtask

  task automatic test_mult();
    run_md(3'd1, 32'hFFFF_FFFD, 32'd7, "mult");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFEB) begin failures++; $display("FAIL mult const: got %h%h expected ffffffffffffffeb", HI, LO); end
    run_md(3'd2, 32'hFFFF_FFFD, 32'd7, "multu");
    checks++;
    if ({HI, LO} !== 64'h0000_0006_FFFF_FFEB) begin failures++; $display("FAIL multu const: got %h%h expected 00000006ffffffeb", HI, LO); end
    for (int i = 0; i < 4; i++) run_md(3'(1 + (i % 2)), $urandom, $urandom, "mult_rand");
  endtask

  task automatic test_div();
    logic [31:0] b;
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, "div");
    checks++;
    if ({HI, LO} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div const: got %h/%h expected ffffffff/fffffffd", HI, LO); end
    run_md(3'd4, 32'd7, 32'd0, "divu_zero");
    checks++;
    if ({HI, LO} !== 64'h0000_0007_FFFF_FFFF) begin failures++; $display("FAIL divu0 const: got %h/%h expected 00000007/ffffffff", HI, LO); end
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_min");
    checks++;
    if ({HI, LO} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL divmin const: got %h/%h expected 00000000/80000000", HI, LO); end
    run_md(3'd3, 32'hFFFF_FF00, 32'd0, "div_zero_neg");
    for (int i = 0; i < 6; i++) begin
      b = $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 15)) - 32'd7;
      run_md(3'(3 + (i % 2)), $urandom, b, "div_rand");
    end
  endtask

  task automatic test_alu_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      EXMEMop = (r < 5) ? 2'd0 : (r == 5) ? 2'd1 : (r == 6) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 3);
      MDop = (r == 0) ? 3'd0 : (r == 1) ? 3'd5 : (r == 2) ? 3'd6 : 3'd7;
      busAMUX = 2'($urandom); busBMUX = 2'($urandom);
      busA = $urandom; busB = $urandom; Imm = $urandom; PCplus4 = $urandom;
      WB_RegWriteData = $urandom; Shamt = 5'($urandom);
      ALUSrcA = 1'($urandom); ALUSrcB = 1'($urandom); ALUorRA = 1'($urandom); Sign = 1'($urandom);
      ALUCtrl = 5'($urandom_range(0, 10));
      RegWrite = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom); MemtoReg = 1'($urandom);
      WriteRegAddr = 5'($urandom); rt = 5'($urandom);
      model_edge(0);
      tick();
      checks++;
      if (dut_exmem !== exp_exmem) begin failures++; $display("FAIL alu_rand[%0d]: got %h expected %h", i, dut_exmem, exp_exmem); end
    end
    set_idle();
  endtask

  task automatic test_mflo_stall();
    int n, bubbles;
    set_idle();
    MDop = 3'd1; busA = 6; busB = 7;
    model_edge(0);
    tick();
    {m_hi, m_lo} = m_md(3'd1, 32'd6, 32'd7);
    MDop = 3'd6; RegWrite = 1; WriteRegAddr = 9; busA = 0; busB = 0;
    n = 0; bubbles = 0;
    #1;
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      model_edge(1);
      tick();
      if (EXMEM_RegWrite === 1'b0) bubbles++;
      #1;
    end
    checks++;
    if (n != W + 1) begin failures++; $display("FAIL mflo stall_cycles: got %0d expected %0d", n, W + 1); end
    checks++;
    if (bubbles != n) begin failures++; $display("FAIL mflo bubbles: got %0d expected %0d", bubbles, n); end
    model_edge(0);
    tick();
    checks++;
    if (EXMEM_ALUout !== 32'd42 || EXMEM_RegWrite !== 1'b1) begin
      failures++; $display("FAIL mflo result: got %0d rw=%b expected 42 rw=1", EXMEM_ALUout, EXMEM_RegWrite);
    end
    checks++;
    if (dut_exmem !== exp_exmem) begin failures++; $display("FAIL mflo entry: got %h expected %h", dut_exmem, exp_exmem); end
    set_idle();
  endtask

  task automatic test_hold_flush();
    logic [31:0] a, b;
    int n;
    a = $urandom; b = $urandom;
    set_idle();
    MDop = 3'd1; busA = a; busB = b; RegWrite = 1; WriteRegAddr = 5; rt = 6; MemtoReg = 1;
    model_edge(0);
    tick();
    MDop = 3'd6; EXMEMop = 2'd2;
    for (int i = 0; i < 3; i++) begin
      model_edge(1);
      tick();
    end
    #1;
    checks++;
    if (stall_req !== 1'b1) begin failures++; $display("FAIL hold stall_req: got %b expected 1", stall_req); end
    checks++;
    if (dut_exmem !== exp_exmem) begin failures++; $display("FAIL hold entry: got %h expected %h", dut_exmem, exp_exmem); end
    EXMEMop = 2'd0;
    model_edge(1);
    tick();
    checks++;
    if (dut_exmem !== 78'd0) begin failures++; $display("FAIL stall bubble: got %h expected 0", dut_exmem); end
    set_idle();
    n = 0;
    while (md_busy === 1'b1 && n < 100) begin n++; model_edge(0); tick(); end
    {m_hi, m_lo} = m_md(3'd1, a, b);
    checks++;
    if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL hold mult: got %h%h expected %h%h", HI, LO, m_hi, m_lo); end
    MDop = 3'd3; busA = $urandom; busB = $urandom; EXMEMop = 2'd1; RegWrite = 1;
    model_edge(0);
    tick();
    set_idle();
    #1;
    checks++;
    if (md_busy !== 1'b0) begin failures++; $display("FAIL flush nostart: got busy %b expected 0", md_busy); end
    checks++;
    if ({HI, LO} !== {m_hi, m_lo}) begin failures++; $display("FAIL flush hilo: got %h%h expected %h%h", HI, LO, m_hi, m_lo); end
    checks++;
    if (dut_exmem !== exp_exmem) begin failures++; $display("FAIL flush entry: got %h expected %h", dut_exmem, exp_exmem); end
  endtask

  task automatic test_reset_mid_op();
    set_idle();
    MDop = 3'd4; busA = $urandom; busB = 32'd3;
    model_edge(0);
    tick();
    set_idle();
    for (int i = 0; i < 10; i++) begin model_edge(0); tick(); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_exmem = '0; m_hi = '0; m_lo = '0;
    checks++;
    if (md_busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b expected 0", md_busy); end
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0) begin failures++; $display("FAIL midreset hilo: got %h/%h expected 0/0", HI, LO); end
    checks++;
    if (dut_exmem !== 78'd0) begin failures++; $display("FAIL midreset exmem: got %h expected 0", dut_exmem); end
    run_md(3'd4, $urandom, 32'($urandom_range(1, 1000)), "post_reset_divu");
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_mult();
    test_div();
    test_alu_random();
    test_mflo_stall();
    test_hold_flush();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage with an EX/MEM pipeline register, operand forwarding, and an iterative multiply/divide unit holding HI/LO. It sits between the ID/EX register and the MEM stage, taking over the role of the single-cycle execute stage. It adds configurable data width, MFHI/MFLO, and a stall request whenever a multi-cycle operation blocks the instruction in EX.

## Interface
Parameters:
- DATA_W, 32, datapath width; must be even and at least 8
- RADDR_W, 5, register address width
- CTRL_W, 5, ALUCtrl width, passed unchanged to the existing ALU (ALU is instantiated at DATA_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- EXMEMop  in  2  0 advance, 1 flush (load bubble), 2/3 hold
- busAMUX, busBMUX  in  2 each  forward select: 0 busA/busB, 1 EXMEM_ALUout, 2 WB_RegWriteData, 3 treated as 0
- busA, busB, Imm, PCplus4, WB_RegWriteData  in  DATA_W each  operands
- Shamt  in  5  shift amount, zero-extended
- ALUSrcA, ALUSrcB, ALUorRA, Sign  in  1 each  same meaning as the current execute stage
- ALUCtrl  in  CTRL_W  ALU operation
- MDop  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 none
- RegWrite, MemRead, MemWrite, MemtoReg  in  1 each  control bits for MEM/WB
- WriteRegAddr, rt  in  RADDR_W each
- stall_req  out  1  combinational; hazard unit must hold IF/ID and ID/EX while high
- md_busy  out  1  multiply/divide unit is iterating
- EXMEM_ALUout, EXMEM_MemWriteData  out  DATA_W each
- EXMEM_RegWrite, EXMEM_MemRead, EXMEM_MemWrite, EXMEM_MemtoReg  out  1 each
- EXMEM_WriteRegAddr, EXMEM_rt  out  RADDR_W each
- HI, LO  out  DATA_W each  architectural HI/LO registers

## Operation
- Operand path:
  - realA and realB are selected by busAMUX/busBMUX.
  - ALU input 1 is realA if ALUSrcA=0, else the zero-extended Shamt.
  - ALU input 2 is realB if ALUSrcB=0, else Imm.
- Result selection:
  - MDop=5 selects HI; MDop=6 selects LO.
  - Otherwise, ALUorRA=1 selects PCplus4 and ALUorRA=0 selects the ALU result.
- EXMEM_MemWriteData captures realB (the forwarded value).
- stall_req = md_busy AND MDop is in 1..6.
- EX/MEM register update, highest priority first:
  - reset: all outputs are 0.
  - EXMEMop hold: all EXMEM_* keep their values.
  - EXMEMop flush, or stall_req: load a bubble; all EXMEM_* become 0.
  - Otherwise: load the new values.
- MD start condition: MDop is in 1..4, EXMEMop=0, and md_busy=0 at the edge.
  - realA is captured as the dividend/multiplicand; realB as the divisor/multiplier.
  - An MD instruction writes no GPR; the EX/MEM entry advances with the control bits as supplied (decode drives RegWrite=0).
- MD state machine, states IDLE, ITER, FIX:
  - IDLE to ITER on start. For signed ops, operand magnitudes are taken and the result signs are recorded.
  - ITER: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counted 0..DATA_W-1.
  - ITER to FIX after DATA_W steps.
  - FIX: apply signs, write HI/LO, go to IDLE.
- Multiply result: {HI,LO} = full 2·DATA_W-bit product.
- Divide result: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend. No exception.
  - Signed MIN / -1: LO = MIN, HI = 0.
- Flush or hold of the EX/MEM register does not abort an op already in ITER/FIX.
- Reset aborts the unit and clears HI/LO to 0.

## Timing
- ALU and forwarding path: 1 cycle, result visible in EXMEM_ALUout after the next edge.
- MD unit:
  - md_busy rises the cycle after the start edge E0 and stays high exactly DATA_W+1 cycles.
  - HI/LO update on edge E0+DATA_W+1, the same edge md_busy falls.
  - Full latency from start to HI/LO valid is DATA_W+1 cycles.
- An MFHI/MFLO or second MD op in EX during md_busy: stall_req is held high and one bubble is inserted per cycle.
  - In the first cycle md_busy=0, an MFHI/MFLO reads the new HI/LO, or a new MD op starts.
- Start and completion never overlap: a new start requires md_busy=0 at the edge.
- Reset is checked only on the rising clk edge. After reset: EXMEM_* = 0, HI = LO = 0, md_busy = 0, state IDLE.

## Test plan
- Forwarding:
  - Stimulus: EXMEM_ALUout=5 from the prior ADD; busA=1, busAMUX=1, busB=7, ALU add.
  - Required: EXMEM_ALUout=12.
  - With busAMUX=2 and WB_RegWriteData=100: EXMEM_ALUout=107.
- MULT:
  - Stimulus: MULT with realA=-3, realB=7.
  - Required: md_busy high 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - With MULTU on the same operands: HI=0x00000006, LO=0xFFFFFFEB.
- DIV:
  - Stimulus: DIV -7/2.
  - Required: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Further cases: DIVU 7/0 gives LO=0xFFFFFFFF, HI=7. DIV 0x80000000/-1 gives LO=0x80000000, HI=0.
- MFLO stall:
  - Stimulus: MULT 6·7, then MFLO immediately following.
  - Required: stall_req high 33 cycles with bubbles (EXMEM_RegWrite=0); then EXMEM_ALUout=42 with RegWrite as supplied.
- Hold/flush priority:
  - EXMEMop=2 during a stall: EX/MEM unchanged.
  - EXMEMop=1 while an MD op is in EX and md_busy=0: no start, HI/LO unchanged.
- Reset mid-operation:
  - Stimulus: reset asserted 10 cycles into DIVU.
  - Required: next edge gives md_busy=0, HI=LO=0, all EXMEM_* = 0; the next MD op starts normally.
